// File: rtl/and4_sweep_ctrl.sv
// Sweep sequencer that exercises a 4-input AND gate over all 16 vectors and reports the results.
// Optional macro SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module and4_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       dut_d,
    input  logic       dut_e,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic       fail_valid,
    output logic [3:0] first_fail_vec
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       vec;
    logic [CNT_W-1:0] cnt;
    logic             mismatch;
    logic             stop_now;

    assign mismatch = (dut_e != (&vec));

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    // Gate inputs come straight from the vector register so they never glitch on input changes
    assign dut_a = vec[3];
    assign dut_b = vec[2];
    assign dut_c = vec[1];
    assign dut_d = vec[0];

    assign busy = (state == SETTLE) || (state == SAMPLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (stop_now || (vec == 4'hF)) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SETTLE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Abort wins over sampling, so a vector sampled on the abort edge is not scored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec            <= '0;
            cnt            <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        vec            <= '0;
                        cnt            <= '0;
                        err_count      <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_vec <= '0;
                        pass           <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (abort) begin
                        vec  <= '0;
                        cnt  <= '0;
                        pass <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (abort) begin
                        vec  <= '0;
                        cnt  <= '0;
                        pass <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            err_count <= err_count + 5'd1;
                            if (!fail_valid) begin
                                first_fail_vec <= vec;
                                fail_valid     <= 1'b1;
                            end
                        end
                        if (!stop_now && (vec != 4'hF)) begin
                            vec <= vec + 4'd1;
                        end
                    end
                end
                DONE: begin
                    pass <= (err_count == 5'd0);
                end
                default: begin
                    vec <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_and4_sweep_ctrl.sv
// Randomised self-checking bench for and4_sweep_ctrl; the gate under test is a truth table the bench picks.
module tb_and4_sweep_ctrl;

    localparam int S  = 4;
    localparam int S1 = S + 1;
    localparam logic [15:0] GOOD_TT = 16'h8000;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       dut_a, dut_b, dut_c, dut_d;
    logic       dut_e;
    logic       busy, done, pass, fail_valid;
    logic [4:0] err_count;
    logic [3:0] first_fail_vec;
    logic [15:0] gate_tt;

    int n_vec;
    int n_bad;

    and4_sweep_ctrl #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d), .dut_e(dut_e),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail_vec(first_fail_vec)
    );

    // Gate model: output looked up from a truth table indexed by {a,b,c,d}
    assign dut_e = gate_tt[{dut_a, dut_b, dut_c, dut_d}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: number of wrong answers among the first n vectors, and lowest wrong vector
    function automatic int model_errs(input logic [15:0] tt, input int n);
        int e = 0;
        for (int k = 0; k < n; k++)
            if (tt[k] != (k == 15)) e++;
        return e;
    endfunction

    function automatic int model_first(input logic [15:0] tt, input int n);
        for (int k = 0; k < n; k++)
            if (tt[k] != (k == 15)) return k;
        return -1;
    endfunction

    task automatic run_sweep(input string name, input logic [15:0] tt,
                             input int abort_at, input int restart_at);
        int d_at, errs, first, n_seen, exp_vec, quiet;
        logic [3:0] gvec;
        errs  = model_errs(tt, 16);
        first = model_first(tt, 16);
        d_at  = 16 * S1;
`ifdef SWEEP_STOP_ON_FAIL_EN
        if (first >= 0) begin
            d_at = (first + 1) * S1;
            errs = 1;
        end
`endif
        gate_tt = tt;
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t <= d_at + 1; t++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            gvec  = {dut_a, dut_b, dut_c, dut_d};
            if (t == abort_at) begin
                n_seen = (abort_at - 1) / S1;
                errs   = model_errs(tt, n_seen);
                first  = model_first(tt, n_seen);
`ifdef SWEEP_STOP_ON_FAIL_EN
                if (errs > 1) errs = 1;
`endif
                n_vec++;
                if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || gvec !== 4'd0 ||
                    err_count !== 5'(errs) || fail_valid !== (first >= 0) ||
                    first_fail_vec !== ((first >= 0) ? 4'(first) : 4'd0)) begin
                    n_bad++;
                    $display("[TB] FAIL %s abort_state: busy=%b done=%b pass=%b vec=%h err=%0d fv=%b ff=%h, want 0 0 0 0 %0d %b %0d",
                             name, busy, done, pass, gvec, err_count, fail_valid, first_fail_vec,
                             errs, first >= 0, (first >= 0) ? first : 0);
                end
                quiet = 1;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (done !== 1'b0 || busy !== 1'b0) quiet = 0;
                end
                n_vec++;
                if (quiet != 1) begin
                    n_bad++;
                    $display("[TB] FAIL %s no_done_after_abort: activity seen, want idle", name);
                end
                return;
            end
            if (t < d_at) begin
                exp_vec = t / S1;
                n_vec++;
                if (busy !== 1'b1 || done !== 1'b0 || gvec !== 4'(exp_vec) || pass !== 1'b0) begin
                    n_bad++;
                    $display("[TB] FAIL %s run_t%0d: busy=%b done=%b vec=%h pass=%b, want 1 0 %h 0",
                             name, t, busy, done, gvec, pass, exp_vec);
                end
                if (t == 0) begin
                    n_vec++;
                    if (err_count !== 5'd0 || fail_valid !== 1'b0) begin
                        n_bad++;
                        $display("[TB] FAIL %s cleared_at_start: err=%0d fv=%b, want 0 0",
                                 name, err_count, fail_valid);
                    end
                end
            end else if (t == d_at) begin
                n_vec++;
                if (busy !== 1'b0 || done !== 1'b1) begin
                    n_bad++;
                    $display("[TB] FAIL %s done_t%0d: busy=%b done=%b, want 0 1", name, t, busy, done);
                end
            end else begin
                n_vec++;
                if (done !== 1'b0 || busy !== 1'b0 || pass !== (errs == 0) ||
                    err_count !== 5'(errs) || fail_valid !== (first >= 0) ||
                    first_fail_vec !== ((first >= 0) ? 4'(first) : 4'd0)) begin
                    n_bad++;
                    $display("[TB] FAIL %s result: done=%b busy=%b pass=%b err=%0d fv=%b ff=%h, want 0 0 %b %0d %b %0d",
                             name, done, busy, pass, err_count, fail_valid, first_fail_vec,
                             errs == 0, errs, first >= 0, (first >= 0) ? first : 0);
                end
            end
            if (t + 1 == abort_at) abort = 1'b1;
            if (t + 1 == restart_at) start = 1'b1;
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if ({dut_a, dut_b, dut_c, dut_d} !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
            pass !== 1'b0 || err_count !== 5'd0 || fail_valid !== 1'b0 || first_fail_vec !== 4'd0) begin
            n_bad++;
            $display("[TB] FAIL reset_values: abcd=%b%b%b%b busy=%b done=%b pass=%b err=%0d fv=%b ff=%h, want all 0",
                     dut_a, dut_b, dut_c, dut_d, busy, done, pass, err_count, fail_valid, first_fail_vec);
        end
    endtask

    task automatic test_healthy();
        run_sweep("healthy", GOOD_TT, -1, -1);
        repeat (3) @(negedge clk);
        n_vec++;
        if (pass !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL pass_held: pass=%b, want 1", pass);
        end
    endtask

    task automatic test_stuck();
        run_sweep("stuck1", 16'hFFFF, -1, -1);
        run_sweep("stuck0", 16'h0000, -1, -1);
    endtask

    task automatic test_random_gates();
        logic [15:0] tt;
        for (int i = 0; i < 6; i++) begin
            tt = 16'($urandom);
            run_sweep("random_gate", tt, -1, -1);
        end
    endtask

    task automatic test_abort();
        run_sweep("abort30", GOOD_TT, 30, -1);
        run_sweep("after_abort", GOOD_TT, -1, -1);
        run_sweep("abort_rand", 16'($urandom), $urandom_range(1, 2 * S1), -1);
    endtask

    task automatic test_restart_ignored();
        run_sweep("restart20", GOOD_TT, -1, 20);
    endtask

    task automatic test_start_abort_together();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        n_vec++;
        if (busy !== 1'b0 || pass !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL start_with_abort: busy=%b pass=%b, want 0 1", busy, pass);
        end
    endtask

    task automatic test_async_reset();
        gate_tt = GOOD_TT;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({dut_a, dut_b, dut_c, dut_d} !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
            pass !== 1'b0 || err_count !== 5'd0 || fail_valid !== 1'b0 || first_fail_vec !== 4'd0) begin
            n_bad++;
            $display("[TB] FAIL async_reset: abcd=%b%b%b%b busy=%b err=%0d, want all 0",
                     dut_a, dut_b, dut_c, dut_d, busy, err_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        run_sweep("b2b_first", 16'hFFFF, -1, -1);
        run_sweep("b2b_second", GOOD_TT, -1, -1);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        gate_tt = GOOD_TT;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_healthy();
        test_start_abort_together();
        test_stuck();
        test_random_gates();
        test_abort();
        test_restart_ignored();
        test_async_reset();
        test_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/and4_sweep_ctrl.md
Name: and4_sweep_ctrl

Overview:
- Self-checking sequencer for a 4-input AND gate under test.
- Drives all 16 input vectors onto the gate's a/b/c/d inputs, waits a settle window, then samples output e and compares it against the expected AND.
- Reports pass/fail, error count and first failing vector.
- Sits between the gate (DUT) and a system bench or BIST top level; all gate inputs are owned by this block.

Parameters:
- SETTLE_CYCLES, 4, clock cycles between driving a vector and sampling e; legal range 1..255.
- CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sweep; sampled only in IDLE.
- abort  input  1  cancel sweep; returns to IDLE.
- dut_a  output  1  gate input a = vec[3].
- dut_b  output  1  gate input b = vec[2].
- dut_c  output  1  gate input c = vec[1].
- dut_d  output  1  gate input d = vec[0].
- dut_e  input  1  gate output, sampled synchronously.
- busy  output  1  high in SETTLE/SAMPLE.
- done  output  1  one-cycle pulse at end of sweep.
- pass  output  1  1 when the last completed sweep had zero mismatches; held until next start.
- err_count  output  5  mismatch count, 0..16.
- fail_valid  output  1  1 once any mismatch is recorded in the current sweep.
- first_fail_vec  output  4  vector {a,b,c,d} of the first mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - vec=0, so dut_a..dut_d=0.
  - busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail_vec=0, settle counter=0.
- dut_a..dut_d are driven directly from the vec register (no combinational path from inputs).
- IDLE:
  - start=1 and abort=0 -> vec<=0, err_count<=0, fail_valid<=0, first_fail_vec<=0, pass<=0, counter<=0; go to SETTLE.
  - start and abort both high -> stay in IDLE.
- SETTLE:
  - Counter increments each cycle.
  - When counter==SETTLE_CYCLES-1, clear counter and go to SAMPLE.
  - Each vector therefore spends SETTLE_CYCLES cycles in SETTLE.
- SAMPLE (1 cycle):
  - Expected = &vec. On a mismatch, err_count<=err_count+1.
  - On a mismatch with fail_valid=0: first_fail_vec<=vec, fail_valid<=1.
  - If vec==15, go to DONE.
  - Otherwise vec<=vec+1 and go to SETTLE.
  - vec never wraps during a sweep.
- DONE (1 cycle):
  - done=1 and pass<=(err_count==0); go to IDLE.
  - vec holds 15 until the next start.
- Timing (cycle 0 = the edge that samples start):
  - Vector k is sampled at cycle (k+1)*(SETTLE_CYCLES+1).
  - done is high in cycle 16*(SETTLE_CYCLES+1)+1.
- abort=1 in SETTLE/SAMPLE:
  - Next state is IDLE; no done pulse; pass<=0.
  - err_count, fail_valid and first_fail_vec keep their values; vec<=0.
- abort in DONE: ignored, because DONE completes in one cycle.
- start while not in IDLE: ignored.
- Reset mid-sweep: immediate return to the reset values above.
- err_count maximum is 16 and fits in 5 bits, so no saturation logic is needed.

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- Defined: a mismatch in SAMPLE goes directly to DONE after recording it; err_count ends at 1 and pass=0.
- Undefined: all 16 vectors are always swept.

Test Plan:
- Healthy AND gate, SETTLE_CYCLES=4, start pulse at cycle 0:
  - Vectors 0..15 appear on a..d, each held 5 cycles.
  - done pulse at cycle 81, pass=1, err_count=0, fail_valid=0.
- Gate output stuck-at-1:
  - err_count=15, fail_valid=1, first_fail_vec=4'b0000, pass=0, done at cycle 81.
- Gate output stuck-at-0:
  - err_count=1, first_fail_vec=4'b1111, pass=0.
- abort at cycle 30 with a healthy gate:
  - IDLE at cycle 31, busy=0, no done pulse, pass=0, dut_a..d=0.
  - A new start completes normally with pass=1.
- Other healthy-gate sweeps:
  - rst_n low at cycle 40: all outputs are 0 immediately, without waiting for clk.
  - start pulsed again at cycle 20: ignored, done still at cycle 81.
- SWEEP_STOP_ON_FAIL_EN defined, stuck-at-1 gate, SETTLE_CYCLES=4:
  - done at cycle 6, err_count=1, first_fail_vec=0, pass=0.
